pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Parametrised program-counter stage for the MIPS front end. Holds the fetch address, computes
//   PC+4 internally, and selects the next PC among exception vector, return-address-stack pop,
//   jump/call target, branch target and sequential flow. Provides stall hold, a circular
//   return-address stack (RAS) and target-alignment detection. Feeds instruction memory and IF/ID.
// PARAMETERS
//   WIDTH         32             address width in bits (>= 8)
//   RESET_VECTOR  0              PC value loaded on reset
//   EXC_VECTOR    32'h0000_0180  PC value loaded on exc; truncated/zero-extended to WIDTH
//   RAS_DEPTH     4              return-address-stack entries; power of 2, >= 2
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous, active-low reset
//   stall          in   1      hold PC and RAS (ignored when exc=1)
//   exc            in   1      exception redirect to EXC_VECTOR
//   ret            in   1      return: pop RAS top into PC
//   call           in   1      call: PC<=jump_target, push PC+4
//   jump           in   1      PC<=jump_target
//   jump_target    in   WIDTH  target for jump/call
//   branch_taken   in   1      PC<=branch_target
//   branch_target  in   WIDTH  branch target
//   pc             out  WIDTH  current fetch address (registered)
//   pc_plus4       out  WIDTH  pc+4, combinational, modulo 2^WIDTH
//   ras_empty      out  1      RAS count == 0 (derived from registered count)
//   ras_full       out  1      RAS count == RAS_DEPTH
//   misaligned     out  1      registered 1-cycle pulse: last loaded target had addr[1:0]!=0
//   ret_underflow  out  1      registered 1-cycle pulse: ret issued with RAS empty
// BEHAVIOUR
//   - Reset (reset=0, async): pc=RESET_VECTOR; RAS count=0, top pointer=0, entries=0;
//     misaligned=0, ret_underflow=0; ras_empty=1, ras_full=0. Takes effect immediately.
//   - All state updates on posedge clk; latency 1 cycle from select inputs to pc.
//   - Next-PC priority (highest first): exc > stall > ret > call > jump > branch_taken > pc+4.
//       exc    : pc<=EXC_VECTOR; RAS unchanged; overrides stall.
//       stall  : pc, RAS, pulse outputs hold/clear (pulses go 0); no other input acted on.
//       ret    : count>0 -> pc<=RAS[top], count-1, top-1 (mod RAS_DEPTH).
//                count==0 -> pc<=pc+4, ret_underflow=1 next cycle, RAS unchanged.
//       call   : pc<=jump_target; push pc+4: top+1 (mod RAS_DEPTH), RAS[top]<=pc+4,
//                count=min(count+1,RAS_DEPTH). Full -> oldest entry overwritten (wrap).
//       jump   : pc<=jump_target. branch_taken: pc<=branch_target.
//   - call and ret both high: ret wins, call ignored (no push). jump and call both high: call.
//   - Alignment: any target loaded from jump_target/branch_target/RAS with bits[1:0]!=0 is
//     loaded with bits[1:0] forced to 2'b00 and misaligned=1 for exactly the next cycle.
//     EXC_VECTOR/RESET_VECTOR are not checked.
//   - Sequential overflow: pc=2^WIDTH-4 -> next pc=0, no flag.
//   - Pulse outputs default 0 each cycle unless set by the current update.
//   - Reset asserted mid-sequence discards RAS and pending pulses; first post-reset fetch at
//     RESET_VECTOR.
// TESTING
//   1 reset=0 then release, no controls, 4 clks -> pc 0,4,8,C,10; ras_empty=1.
//   2 At pc=0x20 call jump_target=0x100; next cycle ret -> pc 0x100 then 0x24; ras_empty=1.
//   3 RAS_DEPTH=4: 5 nested calls (pushes A..E), 5 rets -> pops E,D,C,B then
//     ret_underflow=1 with pc=prev+4; ras_full=1 after 4th push.
//   4 stall=1 with jump=1,target 0x40 for 3 clks -> pc held; then exc=1 with stall=1
//     -> pc=0x180.
//   5 branch_taken=1, branch_target=0x203 -> pc=0x200, misaligned=1 for one cycle then 0.
//   6 call=1 and ret=1 together, RAS top=0x50 -> pc=0x50, count-1, no push;
//     async reset mid-run -> pc=RESET_VECTOR immediately, ras_empty=1.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection, circular return-address stack
// and target-alignment detection for the MIPS front end.
module pc_unit #(
   parameter int unsigned       WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [31:0]       EXC_VECTOR   = 32'h0000_0180,
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             stall_i,
   input  logic             exc_i,
   input  logic             ret_i,
   input  logic             call_i,
   input  logic             jump_i,
   input  logic [WIDTH-1:0] jump_target_i,
   input  logic             branch_taken_i,
   input  logic [WIDTH-1:0] branch_target_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_plus4_o,
   output logic             ras_empty_o,
   output logic             ras_full_o,
   output logic             misaligned_o,
   output logic             ret_underflow_o
);

   localparam int unsigned      PTR_W  = $clog2(RAS_DEPTH);
   localparam int unsigned      CNT_W  = PTR_W + 1;
   localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PTR_W-1:0] rasTop_q, rasTop_d;
   logic [CNT_W-1:0] rasCount_q, rasCount_d;
   logic             misaligned_q, misaligned_d;
   logic             retUnderflow_q, retUnderflow_d;
   logic             pushEn;
   logic             loadTarget;
   logic [WIDTH-1:0] rawTarget;
   logic [WIDTH-1:0] pcPlus4;
   logic             rasEmpty;
   logic             rasFull;

   assign pcPlus4  = pc_q + WIDTH'(4);
   assign rasEmpty = (rasCount_q == '0);
   assign rasFull  = (rasCount_q == CNT_W'(RAS_DEPTH));

   // Redirect targets go through one alignment path so that jump, branch and
   // RAS pops all force bits[1:0] low and flag it the same way.
   always_comb begin
      pc_d           = pcPlus4;
      rasTop_d       = rasTop_q;
      rasCount_d     = rasCount_q;
      misaligned_d   = 1'b0;
      retUnderflow_d = 1'b0;
      pushEn         = 1'b0;
      loadTarget     = 1'b0;
      rawTarget      = '0;
      if (exc_i) begin
         pc_d = EXC_PC;
      end else if (stall_i) begin
         pc_d = pc_q;
      end else if (ret_i) begin
         if (!rasEmpty) begin
            rawTarget  = ras_q[rasTop_q];
            loadTarget = 1'b1;
            rasTop_d   = rasTop_q - PTR_W'(1);
            rasCount_d = rasCount_q - CNT_W'(1);
         end else begin
            retUnderflow_d = 1'b1;
         end
      end else if (call_i) begin
         rawTarget  = jump_target_i;
         loadTarget = 1'b1;
         pushEn     = 1'b1;
         rasTop_d   = rasTop_q + PTR_W'(1);
         if (!rasFull) begin
            rasCount_d = rasCount_q + CNT_W'(1);
         end
      end else if (jump_i) begin
         rawTarget  = jump_target_i;
         loadTarget = 1'b1;
      end else if (branch_taken_i) begin
         rawTarget  = branch_target_i;
         loadTarget = 1'b1;
      end
      if (loadTarget) begin
         pc_d         = {rawTarget[WIDTH-1:2], 2'b00};
         misaligned_d = |rawTarget[1:0];
      end
   end

   // A push when full simply advances the pointer onto the oldest entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q           <= RESET_VECTOR;
         rasTop_q       <= '0;
         rasCount_q     <= '0;
         misaligned_q   <= 1'b0;
         retUnderflow_q <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         pc_q           <= pc_d;
         rasTop_q       <= rasTop_d;
         rasCount_q     <= rasCount_d;
         misaligned_q   <= misaligned_d;
         retUnderflow_q <= retUnderflow_d;
         if (pushEn) begin
            ras_q[rasTop_d] <= pcPlus4;
         end
      end
   end

   assign pc_o            = pc_q;
   assign pc_plus4_o      = pcPlus4;
   assign ras_empty_o     = rasEmpty;
   assign ras_full_o      = rasFull;
   assign misaligned_o    = misaligned_q;
   assign ret_underflow_o = retUnderflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table of control vectors with hand-derived
// expected PC/flags, queued as a scoreboard and compared one cycle later.
module tb_pc_unit;

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_EXC   = 6'b100000;
   localparam logic [5:0] C_STALL = 6'b010000;
   localparam logic [5:0] C_RET   = 6'b001000;
   localparam logic [5:0] C_CALL  = 6'b000100;
   localparam logic [5:0] C_JMP   = 6'b000010;
   localparam logic [5:0] C_BR    = 6'b000001;

   typedef struct {
      logic [5:0]  ctrl;
      logic [31:0] jt;
      logic [31:0] bt;
      logic [31:0] expPc;
      logic        expMis;
      logic        expUnd;
      logic        expEmpty;
      logic        expFull;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] pc;
      logic        mis;
      logic        und;
      logic        empty;
      logic        full;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        stall, exc, ret, call, jump, branchTaken;
   logic [31:0] jumpTarget, branchTarget;
   logic [31:0] pc, pcPlus4;
   logic        rasEmpty, rasFull, misaligned, retUnderflow;

   int   testsRun;
   int   testsFailed;
   vec_t vecs[$];
   exp_t sb[$];

   pc_unit dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .stall_i         (stall),
      .exc_i           (exc),
      .ret_i           (ret),
      .call_i          (call),
      .jump_i          (jump),
      .jump_target_i   (jumpTarget),
      .branch_taken_i  (branchTaken),
      .branch_target_i (branchTarget),
      .pc_o            (pc),
      .pc_plus4_o      (pcPlus4),
      .ras_empty_o     (rasEmpty),
      .ras_full_o      (rasFull),
      .misaligned_o    (misaligned),
      .ret_underflow_o (retUnderflow)
   );

   // 10-unit clock, first rising edge at t=5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(logic [5:0] c, logic [31:0] j, logic [31:0] b,
                                  logic [31:0] p, logic m, logic u, logic e, logic f);
      vec_t v;
      v.ctrl = c; v.jt = j; v.bt = b; v.expPc = p;
      v.expMis = m; v.expUnd = u; v.expEmpty = e; v.expFull = f;
      return v;
   endfunction

   task automatic checkVal(string name, int idx, logic [31:0] actual, logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, idx, actual, expected);
      end
   endtask

   // Drives one vector, queues its expectations, then advances one clock.
   task automatic applyStimulus(int idx, vec_t v);
      exp_t e;
      {exc, stall, ret, call, jump, branchTaken} = v.ctrl;
      jumpTarget   = v.jt;
      branchTarget = v.bt;
      e.idx = idx; e.pc = v.expPc; e.mis = v.expMis; e.und = v.expUnd;
      e.empty = v.expEmpty; e.full = v.expFull;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: no expectation queued for observed pc 0x%08h", pc);
         return;
      end
      e = sb.pop_front();
      checkVal("pc",            e.idx, pc,                    e.pc);
      checkVal("pc_plus4",      e.idx, pcPlus4,               e.pc + 32'd4);
      checkVal("misaligned",    e.idx, {31'd0, misaligned},   {31'd0, e.mis});
      checkVal("ret_underflow", e.idx, {31'd0, retUnderflow}, {31'd0, e.und});
      checkVal("ras_empty",     e.idx, {31'd0, rasEmpty},     {31'd0, e.empty});
      checkVal("ras_full",      e.idx, {31'd0, rasFull},      {31'd0, e.full});
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n = 1'b0;
      {exc, stall, ret, call, jump, branchTaken} = C_NONE;
      jumpTarget   = '0;
      branchTarget = '0;

      // Sequential flow from reset up to 0x20.
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mkVec(C_NONE, 0, 0, 32'(4 * i), 0, 0, 1, 0));
      // Call then return.
      vecs.push_back(mkVec(C_CALL,  32'h100, 0, 32'h100, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h024, 0, 0, 1, 0));
      // Misaligned branch pulse.
      vecs.push_back(mkVec(C_BR,    0, 32'h203, 32'h200, 1, 0, 1, 0));
      vecs.push_back(mkVec(C_NONE,  0, 0,       32'h204, 0, 0, 1, 0));
      // Stall beats jump; exception beats stall.
      for (int i = 0; i < 3; i++)
         vecs.push_back(mkVec(C_STALL | C_JMP, 32'h40, 0, 32'h204, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_EXC | C_STALL, 0, 0, 32'h180, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_JMP,   32'h41, 0,  32'h040, 1, 0, 1, 0));
      vecs.push_back(mkVec(C_JMP,   32'h300, 0, 32'h300, 0, 0, 1, 0));
      // Five nested calls: the fifth overwrites the oldest return address.
      vecs.push_back(mkVec(C_CALL,  32'h400, 0, 32'h400, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_CALL,  32'h500, 0, 32'h500, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_CALL,  32'h600, 0, 32'h600, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_CALL,  32'h700, 0, 32'h700, 0, 0, 0, 1));
      vecs.push_back(mkVec(C_CALL,  32'h800, 0, 32'h800, 0, 0, 0, 1));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h704, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h604, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h504, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h404, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h408, 0, 1, 1, 0));
      vecs.push_back(mkVec(C_NONE,  0, 0,       32'h40C, 0, 0, 1, 0));
      // call+ret together: ret wins, no push.
      vecs.push_back(mkVec(C_JMP,   32'h4C, 0,  32'h04C, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_CALL,  32'h900, 0, 32'h900, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_CALL | C_RET, 32'hAAA, 0, 32'h050, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_NONE,  0, 0,       32'h054, 0, 0, 1, 0));
      // Priority among call/jump/branch.
      vecs.push_back(mkVec(C_CALL | C_JMP, 32'hA00, 0, 32'hA00, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_JMP | C_BR, 32'hB00, 32'hC00, 32'hB00, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_BR,    0, 32'hC00, 32'hC00, 0, 0, 0, 0));
      // Exception leaves the RAS intact.
      vecs.push_back(mkVec(C_EXC,   0, 0,       32'h180, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_RET,   0, 0,       32'h058, 0, 0, 1, 0));
      // Sequential wrap at the top of the address space.
      vecs.push_back(mkVec(C_JMP,   32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_NONE,  0, 0,       32'h000, 0, 0, 1, 0));
      // Stall suppresses an underflowing ret and clears a pending pulse.
      vecs.push_back(mkVec(C_STALL | C_RET, 0, 0, 32'h000, 0, 0, 1, 0));
      vecs.push_back(mkVec(C_BR,    0, 32'h7, 32'h004, 1, 0, 1, 0));
      vecs.push_back(mkVec(C_STALL, 0, 0,     32'h004, 0, 0, 1, 0));
      // Leave a pushed entry and a live pulse for the mid-run reset.
      vecs.push_back(mkVec(C_CALL,  32'h100, 0, 32'h100, 0, 0, 0, 0));
      vecs.push_back(mkVec(C_JMP,   32'h123, 0, 32'h120, 1, 0, 0, 0));

      // Reset state, checked between edges.
      #12;
      checkVal("reset.pc",            0, pc,                    32'h0);
      checkVal("reset.ras_empty",     0, {31'd0, rasEmpty},     32'd1);
      checkVal("reset.ras_full",      0, {31'd0, rasFull},      32'd0);
      checkVal("reset.misaligned",    0, {31'd0, misaligned},   32'd0);
      checkVal("reset.ret_underflow", 0, {31'd0, retUnderflow}, 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(i + 1, vecs[i]);
         checkOutput();
      end

      // Asynchronous reset mid-cycle takes effect without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("midreset.pc",         99, pc,                  32'h0);
      checkVal("midreset.ras_empty",  99, {31'd0, rasEmpty},   32'd1);
      checkVal("midreset.misaligned", 99, {31'd0, misaligned}, 32'd0);
      #1;
      rst_n = 1'b1;
      // RAS contents must be gone: ret underflows from the reset vector.
      applyStimulus(100, mkVec(C_RET, 0, 0, 32'h004, 0, 1, 1, 0));
      checkOutput();
      applyStimulus(101, mkVec(C_NONE, 0, 0, 32'h008, 0, 0, 1, 0));
      checkOutput();

      if (sb.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: %0d expectations left unchecked, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
